// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage feeding the decoder.
//
// Holds a loadable program store and a program counter. One instruction at a time
// is presented on id with a valid/ready handshake. On each accepted instruction
// the PC either advances (wrapping at 2**AW) or takes the decoder's jump target.
// Fetching stops after a HALT instruction has been accepted.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   start      single-cycle pulse, begin fetching from address 0 (IDLE/HALTED only)
//   load_en    program-store write enable (IDLE/HALTED only)
//   load_addr  program-store write address
//   load_data  program-store write data
//   jmp_en     jump request, sampled only on a handshake cycle
//   jmp_addr   jump target
//   id_ready   decoder accepts id this cycle
//   id         instruction presented to the decoder
//   id_valid   id holds a valid instruction
//   pc         address of the instruction being fetched or presented
//   busy       high in FETCH or VALID
//   halted     high in HALTED
module instr_fetch_unit #(
  parameter int unsigned IW      = 18,
  parameter int unsigned AW      = 6,
  parameter logic [3:0]  HALT_OP = 4'b1000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          jmp_en,
  input  logic [AW-1:0] jmp_addr,
  input  logic          id_ready,
  output logic [IW-1:0] id,
  output logic          id_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StHalted} state_e;

  state_e        state_q;
  logic [IW-1:0] id_q;
  logic          id_valid_q;
  logic [AW-1:0] pc_q;
  logic          busy_q;
  logic          halted_q;

  // Program store is deliberately left out of reset so a program survives rst.
  logic [IW-1:0] mem [2**AW];

  logic load_window;
  logic is_halt;

  assign load_window = (state_q == StIdle) || (state_q == StHalted);
  assign is_halt     = (id_q[IW-1 -: 4] == HALT_OP);

  always_ff @(posedge clk) begin
    if (load_window && load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      id_q       <= '0;
      id_valid_q <= 1'b0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StHalted: begin
          if (start) begin
            pc_q     <= '0;
            busy_q   <= 1'b1;
            halted_q <= 1'b0;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          id_q       <= mem[pc_q];
          id_valid_q <= 1'b1;
          state_q    <= StValid;
        end
        StValid: begin
          // id and pc hold indefinitely until the decoder takes the instruction.
          if (id_ready) begin
            id_valid_q <= 1'b0;
            if (is_halt) begin
              // PC stays on the HALT word; a concurrent jump request is dropped.
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
              state_q  <= StHalted;
            end else begin
              pc_q    <= jmp_en ? jmp_addr : pc_q + AW'(1);
              state_q <= StFetch;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign id       = id_q;
  assign id_valid = id_valid_q;
  assign pc       = pc_q;
  assign busy     = busy_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. Expected (pc, id) pairs are queued when a
// run is launched and consumed by a monitor at every handshake.
module tb_instr_fetch_unit;

  localparam int unsigned IW = 18;
  localparam int unsigned AW = 6;

  localparam logic [IW-1:0] W0 = 18'b110010000011011000;
  localparam logic [IW-1:0] W1 = 18'b101101110011101100;
  localparam logic [IW-1:0] W2 = 18'b000110001111001100;
  localparam logic [IW-1:0] W3 = 18'b100010111011001100;
  localparam logic [IW-1:0] W2_NEW = 18'b011100001111000011;
  localparam logic [IW-1:0] N0  = 18'b001000000000000001;
  localparam logic [IW-1:0] HLT = 18'b100000000000000111;
  localparam logic [IW-1:0] N63 = 18'b010011001100110011;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          jmp_en;
  logic [AW-1:0] jmp_addr;
  logic          id_ready;
  logic [IW-1:0] id;
  logic          id_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  instr_fetch_unit #(.IW(IW), .AW(AW), .HALT_OP(4'b1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .id_ready  (id_ready),
    .id        (id),
    .id_valid  (id_valid),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [IW-1:0] model_mem [2**AW];
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [IW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Queue the sequential run from addr 0 through the first HALT word of the model.
  task automatic push_run();
    logic [AW-1:0] a;
    a = '0;
    for (int n = 0; n < 70; n++) begin
      push_exp(a, model_mem[a]);
      if (model_mem[a][IW-1 -: 4] == 4'b1000) break;
      a = a + AW'(1);
    end
  endtask

  // Monitor: every handshake consumes one scoreboard entry.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_id", {14'd0, id}, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sb_id", {14'd0, id}, {14'd0, e.data});
        check_val("sb_pc", {26'd0, pc}, {26'd0, e.addr});
      end
    end
  end

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d,
                           input bit commits);
    @(posedge clk);
    #1;
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    if (commits) model_mem[a] = d;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Leaves time at posedge+1 with word addr presented.
  task automatic wait_pc(input logic [AW-1:0] a, input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (id_valid && pc == a) begin
        hit = 1'b1;
        break;
      end
    end
    check_val({tag, "_reached"}, {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      #1;
      if (halted) begin
        hit = 1'b1;
        break;
      end
    end
    check_val({tag, "_halted"}, {31'd0, hit}, 32'd1);
    check_val({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    jmp_en    = 1'b0;
    jmp_addr  = '0;
    id_ready  = 1'b1;
    #3;
    check_val("rst_id", {14'd0, id}, 32'd0);
    check_val("rst_valid", {31'd0, id_valid}, 32'd0);
    check_val("rst_pc", {26'd0, pc}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Basic program with constant ready: 1-cycle valid pulses, 2-cycle latency.
    load_word(6'd0, W0, 1'b1);
    load_word(6'd1, W1, 1'b1);
    load_word(6'd2, W2, 1'b1);
    load_word(6'd3, W3, 1'b1);
    push_run();
    pulse_start();
    check_val("t1_busy_fetch", {31'd0, busy}, 32'd1);
    check_val("t1_valid_fetch", {31'd0, id_valid}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 8) begin
        check_val("t1_valid_pat", {31'd0, id_valid}, {31'd0, (i % 2 == 1)});
      end else begin
        check_val("t1_halted", {31'd0, halted}, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd0);
        check_val("t1_pc", {26'd0, pc}, 32'd3);
        check_val("t1_valid", {31'd0, id_valid}, 32'd0);
      end
    end
    check_val("t1_sb_empty", exp_q.size(), 32'd0);

    // Backpressure on word 1 for 5 cycles.
    push_run();
    pulse_start();
    @(posedge clk);
    @(posedge clk);
    #1;
    id_ready = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("t2_hold_id", {14'd0, id}, {14'd0, W1});
      check_val("t2_hold_valid", {31'd0, id_valid}, 32'd1);
      check_val("t2_hold_pc", {26'd0, pc}, 32'd1);
      @(posedge clk);
    end
    #1;
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("t2_pc_after", {26'd0, pc}, 32'd2);
    wait_halt("t2");

    // Jump from address 1 to the HALT word at 3.
    push_exp(6'd0, W0);
    push_exp(6'd1, W1);
    push_exp(6'd3, W3);
    pulse_start();
    wait_pc(6'd1, "t3_w1");
    jmp_en   = 1'b1;
    jmp_addr = 6'd3;
    @(posedge clk);
    #1;
    jmp_en = 1'b0;
    check_val("t3_pc_jump", {26'd0, pc}, 32'd3);
    wait_halt("t3");
    check_val("t3_pc_halt", {26'd0, pc}, 32'd3);

    // Jump request without a handshake is ignored.
    push_run();
    pulse_start();
    wait_pc(6'd1, "t3b_w1");
    id_ready = 1'b0;
    jmp_en   = 1'b1;
    jmp_addr = 6'd3;
    @(posedge clk);
    @(posedge clk);
    #1;
    jmp_en   = 1'b0;
    check_val("t3b_pc_held", {26'd0, pc}, 32'd1);
    id_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("t3b_pc_next", {26'd0, pc}, 32'd2);
    wait_halt("t3b");

    // Async reset while presenting word 2.
    push_run();
    pulse_start();
    wait_pc(6'd2, "t5_w2");
    id_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_val("t5_rst_id", {14'd0, id}, 32'd0);
    check_val("t5_rst_valid", {31'd0, id_valid}, 32'd0);
    check_val("t5_rst_pc", {26'd0, pc}, 32'd0);
    check_val("t5_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    #3;
    rst      = 1'b0;
    id_ready = 1'b1;
    push_run();
    pulse_start();
    wait_halt("t5");

    // Load to address 2 while busy is dropped.
    id_ready = 1'b0;
    push_run();
    pulse_start();
    load_word(6'd2, W2_NEW, 1'b0);
    id_ready = 1'b1;
    wait_halt("t6_busy");

    // Same write in HALTED, on the same edge as start, takes effect.
    @(posedge clk);
    #1;
    model_mem[2] = W2_NEW;
    push_run();
    load_en   = 1'b1;
    load_addr = 6'd2;
    load_data = W2_NEW;
    start     = 1'b1;
    @(posedge clk);
    #1;
    load_en = 1'b0;
    start   = 1'b0;
    wait_halt("t6_halted");

    // PC wrap 63 -> 0.
    load_word(6'd0, N0, 1'b1);
    load_word(6'd1, HLT, 1'b1);
    load_word(6'd63, N63, 1'b1);
    push_exp(6'd0, N0);
    push_exp(6'd63, N63);
    push_exp(6'd0, N0);
    push_exp(6'd1, HLT);
    pulse_start();
    wait_pc(6'd0, "t4_w0");
    jmp_en   = 1'b1;
    jmp_addr = 6'd63;
    @(posedge clk);
    #1;
    jmp_en = 1'b0;
    wait_pc(6'd63, "t4_w63");
    @(posedge clk);
    #1;
    check_val("t4_wrap_pc", {26'd0, pc}, 32'd0);
    wait_halt("t4");
    check_val("t4_pc_halt", {26'd0, pc}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
